// File: rtl/core_pkg.sv
// Shared load/store definitions: funct3 encodings of the memory-mode word,
// bit positions inside ram_mode ({funct3, is_store}), the LSU FSM state type
// and small decode helpers for mode legality and alignment.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MODE_ST_BIT = 0;
  localparam int unsigned MODE_F3_LO  = 1;
  localparam int unsigned MODE_F3_HI  = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE,
    ERR
  } lsu_state_e;

  function automatic logic mode_legal(input logic [3:0] mode);
    logic [2:0] f3;
    f3 = mode[MODE_F3_HI:MODE_F3_LO];
    if (mode[MODE_ST_BIT])
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] carries the access size for both signed and unsigned forms.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ram_ctrl_if.sv
// Data-memory port of the load/store unit (req/gnt/rvalid protocol).
//   master : LSU side  - drives mem_req/we/addr/be/wdata, receives gnt/rvalid/rdata
//   slave  : RAM side  - the mirror image
interface lsu_ram_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane helper for 32-bit little-endian memory accesses.
//   funct3_i    : access size/signedness (funct3 encoding)
//   addr_lo_i   : byte offset within the word
//   wdata_i     : raw store data      -> wdata_o : lane-replicated store data
//   rdata_raw_i : raw read word       -> rdata_o : extracted, extended load data
//   be_o        : byte enables for the access
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic        unsigned_ld;

  assign shifted     = rdata_raw_i >> {addr_lo_i, 3'b000};
  assign unsigned_ld = funct3_i[2];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_raw_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7] & ~unsigned_ld}}, shifted[7:0]};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15] & ~unsigned_ld}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store unit: turns one decoded memory request into a single word-aligned
// req/gnt/rvalid transaction, stalls the core with busy and reports completion
// with a one-cycle done (err for misaligned/illegal/timeout).
//   clk, rst_n        : clock, synchronous active-low reset
//   req, ram_mode,
//   addr, wdata       : request from execute ({funct3, is_store}, byte address)
//   busy, done, err,
//   rdata             : status and extended load result (held until next done)
//   dmem              : data-memory port (master side)
module lsu_ram_ctrl
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [3:0]        ram_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  lsu_ram_ctrl_if.master    dmem
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [3:0]        mode_q, mode_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Lane logic is shared: in IDLE it shapes the incoming request, afterwards it
  // extracts read data using the latched mode/offset.
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign al_funct3  = (state_q == IDLE) ? ram_mode[MODE_F3_HI:MODE_F3_LO]
                                        : mode_q[MODE_F3_HI:MODE_F3_LO];
  assign al_addr_lo = (state_q == IDLE) ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3_i    (al_funct3),
    .addr_lo_i   (al_addr_lo),
    .wdata_i     (wdata),
    .rdata_raw_i (dmem.mem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      addr_lo_q   <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_lo_q   <= addr_lo_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_lo_d   = addr_lo_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          mode_d    = ram_mode;
          addr_lo_d = addr[1:0];
          if (!mode_legal(ram_mode) ||
              misaligned(ram_mode[MODE_F3_HI:MODE_F3_LO], addr[1:0])) begin
            state_d = ERR;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = ram_mode[MODE_ST_BIT];
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            cnt_d       = '0;
          end
        end
      end
      REQ: begin
        if (dmem.mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          state_d   = mode_q[MODE_ST_BIT] ? DONE : WAIT_R;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_R: begin
        if (dmem.mem_rvalid) begin
          rdata_d = al_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE) || (state_q == ERR);
  assign err   = (state_q == ERR);
  assign rdata = rdata_q;

  assign dmem.mem_req   = mem_req_q;
  assign dmem.mem_we    = mem_we_q;
  assign dmem.mem_addr  = mem_addr_q;
  assign dmem.mem_be    = mem_be_q;
  assign dmem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Self-checking bench for lsu_ram_ctrl: a memory responder with programmable
// grant/rvalid delays, a scoreboard of expected completions, and directed
// transactions for the store/load/error/timeout/reset cases.
module tb_lsu_ram_ctrl;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic [3:0]        ram_mode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  lsu_ram_ctrl_if #(.ADDR_W(ADDR_W)) ramif ();

  lsu_ram_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ram_mode (ram_mode),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .dmem     (ramif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: drive req, respond on the memory port, and compare the
  // completion against the scoreboard. rv_wait < 0 means rvalid never comes.
  task automatic do_txn(input string tag, input logic [3:0] mode, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd_word,
                        input int gnt_wait, input int rv_wait, input bit exp_access,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input bit exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    sb_item_t it;
    int  cyc;
    int  gcyc;
    bit  seen_req;
    bit  fin;
    @(negedge clk);
    req = 1'b1; ram_mode = mode; addr = a; wdata = wd;
    sb_q.push_back('{exp_err, exp_rdata, exp_lat});
    cyc = 0; gcyc = -1; seen_req = 1'b0; fin = 1'b0;
    while (!fin && cyc < 64) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      ramif.mem_gnt = 1'b0; ramif.mem_rvalid = 1'b0; ramif.mem_rdata = '0;
      if (cyc == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      if (ramif.mem_req && !seen_req) begin
        seen_req = 1'b1;
        check({tag, ".addr"}, ramif.mem_addr, a & 32'hFFFF_FFFC);
        check({tag, ".be"},   32'(ramif.mem_be), 32'(exp_be));
        check({tag, ".we"},   32'(ramif.mem_we), 32'(mode[0]));
        if (mode[0]) check({tag, ".wdata"}, ramif.mem_wdata, exp_wdata);
      end
      if (gcyc >= 0 && cyc == gcyc + 1) check({tag, ".req_drop"}, 32'(ramif.mem_req), 32'd0);
      if (gcyc >= 0 && rv_wait >= 0 && !mode[0] && cyc == gcyc + 1 + rv_wait) begin
        ramif.mem_rvalid = 1'b1;
        ramif.mem_rdata  = rd_word;
      end
      if (ramif.mem_req && gcyc < 0 && cyc >= 1 + gnt_wait) begin
        ramif.mem_gnt = 1'b1;
        gcyc = cyc;
      end
      if (done) begin
        fin = 1'b1;
        if (sb_q.size() == 0) begin
          check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
          it = sb_q.pop_front();
          check({tag, ".err"},   32'(err), 32'(it.err));
          check({tag, ".rdata"}, rdata, it.rdata);
          check({tag, ".lat"},   32'(cyc), 32'(it.lat));
        end
      end
    end
    ramif.mem_gnt = 1'b0; ramif.mem_rvalid = 1'b0;
    check({tag, ".done_seen"}, 32'(fin), 32'd1);
    check({tag, ".access"}, 32'(seen_req), 32'(exp_access));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; ram_mode = '0; addr = '0; wdata = '0;
    ramif.mem_gnt = 1'b0; ramif.mem_rvalid = 1'b0; ramif.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst.busy",   32'(busy), 32'd0);
    check("rst.done",   32'(done), 32'd0);
    check("rst.err",    32'(err), 32'd0);
    check("rst.req",    32'(ramif.mem_req), 32'd0);
    check("rst.we",     32'(ramif.mem_we), 32'd0);
    check("rst.rdata",  rdata, 32'd0);
    check("rst.addr",   ramif.mem_addr, 32'd0);
    check("rst.be",     32'(ramif.mem_be), 32'd0);
    check("rst.wdata",  ramif.mem_wdata, 32'd0);
    rst_n = 1'b1;

    //     tag      mode     addr          wdata         mem_rdata     gw rv acc be       exp_wdata     err  exp_rdata     lat
    do_txn("sw",    4'b0101, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        2);
    do_txn("sb",    4'b0001, 32'h0000_0103, 32'h0000_0080, 32'h0,        0, 0, 1, 4'b1000, 32'h8080_8080, 0, 32'h0,        2);
    do_txn("lb",    4'b0000, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 0, 1, 4'b1000, 32'h0,        0, 32'hFFFF_FF80, 3);
    do_txn("lbu",   4'b1000, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 0, 1, 4'b1000, 32'h0,        0, 32'h0000_0080, 3);
    do_txn("lh",    4'b0010, 32'h0000_0202, 32'h0,         32'h8001_1234, 3, 0, 1, 4'b1100, 32'h0,        0, 32'hFFFF_8001, 6);
    do_txn("lhu",   4'b1010, 32'h0000_0202, 32'h0,         32'h8001_1234, 0, 0, 1, 4'b1100, 32'h0,        0, 32'h0000_8001, 3);
    do_txn("mis",   4'b0100, 32'h0000_0201, 32'h0,         32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 32'h0000_8001, 1);
    do_txn("ill",   4'b0110, 32'h0000_0200, 32'h0,         32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 32'h0000_8001, 1);
    do_txn("tmo",   4'b0100, 32'h0000_0300, 32'h0,         32'h0,        0, -1, 1, 4'b1111, 32'h0,       1, 32'h0000_8001, 2 + TIMEOUT);
    do_txn("sw2",   4'b0101, 32'h0000_0308, 32'h1234_5678, 32'h0,        0, 0, 1, 4'b1111, 32'h1234_5678, 0, 32'h0000_8001, 2);
    do_txn("sh",    4'b0011, 32'h0000_0312, 32'h0000_A5C3, 32'h0,        1, 0, 1, 4'b1100, 32'hA5C3_A5C3, 0, 32'h0000_8001, 3);

    // Reset while waiting for read data: no completion, late rvalid ignored.
    @(negedge clk);
    req = 1'b1; ram_mode = 4'b0100; addr = 32'h0000_0500;
    @(negedge clk);
    req = 1'b0;
    check("rstw.req", 32'(ramif.mem_req), 32'd1);
    ramif.mem_gnt = 1'b1;
    @(negedge clk);
    ramif.mem_gnt = 1'b0;
    check("rstw.busy_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw.busy", 32'(busy), 32'd0);
    check("rstw.done", 32'(done), 32'd0);
    ramif.mem_rvalid = 1'b1; ramif.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    ramif.mem_rvalid = 1'b0; ramif.mem_rdata = '0;
    check("rstw.rdata", rdata, 32'd0);
    check("rstw.done2", 32'(done), 32'd0);
    check("rstw.busy2", 32'(busy), 32'd0);

    do_txn("lw",    4'b0100, 32'h0000_0400, 32'h0,         32'h1234_5678, 0, 2, 1, 4'b1111, 32'h0,        0, 32'h1234_5678, 5);

    check("sb.leftover", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ram_ctrl.md
Name: lsu_ram_ctrl

Overview:
- Load/store unit that consumes the 4-bit memory-mode word produced by the instruction decoder ({funct3, is_store}).
- Turns each accepted request into a single word-aligned transaction on a req/gnt/rvalid data-memory port.
- Generates byte enables and store-data lane placement; returns load data sign- or zero-extended to 32 bits.
- Sits between the execute stage (address = ALU result) and data RAM, and stalls the core via `busy` until `done`.

Parameters:
- ADDR_W, 32, byte-address width on both sides.
- TIMEOUT, 16, maximum cycles to wait for mem_gnt or mem_rvalid before aborting with error (≥2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- req  in  1  request valid; sampled only in IDLE
- ram_mode  in  4  {funct3[2:0], is_store}
- addr  in  ADDR_W  byte address
- wdata  in  32  store data (low bits significant for SB/SH)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, illegal mode, or timeout
- rdata  out  32  extended load data, valid with done (held until next done)
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. busy, done, err, mem_req, mem_we = 0. rdata, mem_addr, mem_be, mem_wdata, timeout counter = 0. Reset mid-transaction abandons it with no done; a late mem_rvalid arriving in IDLE is ignored.
- Legal modes:
  - Loads (is_store=0): funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores (is_store=1): funct3 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned: half-word access with addr[0]=1; word access with addr[1:0]≠0.
- States:
  - IDLE: on req, latch ram_mode, addr, wdata.
    - Illegal or misaligned → ERR.
    - Otherwise → REQ, with mem_* outputs registered so mem_req is high the cycle after req.
  - REQ: hold mem_req and all mem_* stable until mem_gnt.
    - On gnt: store → DONE; load → WAIT_R.
    - mem_req drops the cycle after gnt.
  - WAIT_R: on mem_rvalid, capture and extend mem_rdata into rdata → DONE.
  - DONE: done=1, err=0 for one cycle → IDLE.
  - ERR: done=1, err=1 for one cycle, no memory access, rdata unchanged → IDLE.
- Timeout: counter clears on entering REQ and on entering WAIT_R, and increments each cycle in those states. At count TIMEOUT-1 without the awaited input → ERR. In that case mem_req is deasserted and the transaction is dropped.
- Byte enables:
  - Byte access: mem_be = 4'b0001 << addr[1:0].
  - Half-word access: mem_be = 4'b0011 << addr[1:0].
  - Word access: mem_be = 4'b1111.
- Store data: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves; SW passes wdata unchanged.
- Load extract: select byte/half by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency, no wait states:
  - Store: req at T, mem_req T+1, gnt T+1, done T+2.
  - Load with rvalid at T+2: done T+3.
  - Error: done T+1.
- mem_gnt and mem_rvalid in the same cycle during REQ is not legal for this port; rvalid is sampled only in WAIT_R.
- req while busy is ignored; upstream holds the pipeline on busy.

Decomposition:
- Shared package (core_pkg): funct3 constants (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101), ram_mode bit positions, FSM state enum {IDLE, REQ, WAIT_R, DONE, ERR}.
- One natural combinational sub-module: lsu_align, holding the byte-enable generation, store lane replication and load extract/extension. It is reused by a future instruction-memory loader.

Test Plan:
- SW: addr=0x0000_0104, wdata=0xDEADBEEF, immediate gnt → mem_addr=0x104, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1, done 2 cycles after req, err=0.
- SB then LB/LBU:
  - SB: addr=0x103, wdata=0x0000_0080 → mem_be=1000, mem_wdata=0x80808080.
  - LB: addr=0x103, mem_rdata=0x80_00_00_00 → rdata=0xFFFFFF80.
  - LBU: same address and data → rdata=0x00000080.
- LH: addr=0x202, mem_rdata=0x8001_1234 → rdata=0xFFFF8001; LHU → 0x00008001. Add 3 gnt wait cycles → done delayed exactly 3 cycles.
- Misaligned LW at addr=0x201, and illegal mode {3'b011,0} → err=1 and done one cycle after req, mem_req never asserted, rdata unchanged.
- Timeout: LW with gnt but no rvalid for TIMEOUT=16 cycles → done with err=1, FSM returns to IDLE; a following SW completes normally.
- Reset mid-WAIT_R: rst_n=0 for one cycle → busy=0, no done pulse; a stray rvalid next cycle does not change rdata.
